// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter that lets two requesters share one
// sequential multiplier, with a run timeout.
//
// Ports
//   clk, Reset                 clock, async active-high reset
//   i_req0/1, i_a0/b0, i_a1/b1 level requests and their operands
//   o_gnt0/1                   requester owns the multiplier (LOAD..DONE)
//   o_done0/1                  one-cycle completion pulse
//   o_err                      timeout flag, valid with the done pulse
//   o_result                   product of the last completed transaction
//   o_busy                     high outside IDLE
//   o_m_reset, o_m_run         load strobe / run enable to the multiplier
//   o_m_multiplicand/_multiplier  operands latched at grant
//   i_m_ready, i_m_product     multiplier completion flag and product
module mul_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 40
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 i_req0,
    input  logic                 i_req1,
    input  logic [WIDTH-1:0]     i_a0,
    input  logic [WIDTH-1:0]     i_b0,
    input  logic [WIDTH-1:0]     i_a1,
    input  logic [WIDTH-1:0]     i_b1,
    output logic                 o_gnt0,
    output logic                 o_gnt1,
    output logic                 o_done0,
    output logic                 o_done1,
    output logic                 o_err,
    output logic [2*WIDTH-1:0]   o_result,
    output logic                 o_busy,
    output logic                 o_m_reset,
    output logic                 o_m_run,
    output logic [WIDTH-1:0]     o_m_multiplicand,
    output logic [WIDTH-1:0]     o_m_multiplier,
    input  logic                 i_m_ready,
    input  logic [2*WIDTH-1:0]   i_m_product
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 w_pick1;
    logic                 w_timeout;
    logic                 r_last1;
    logic [CW-1:0]        r_cnt;
    logic                 r_gnt0;
    logic                 r_gnt1;
    logic                 r_done0;
    logic                 r_done1;
    logic                 r_err;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_busy;
    logic                 r_m_reset;
    logic                 r_m_run;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign w_pick1   = i_req1 & (~i_req0 | ~r_last1);
    // Current RUN cycle is the TIMEOUT-th one.
    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_req0 || i_req1) w_next = S_LOAD;
            S_LOAD: w_next = S_RUN;
            S_RUN:  if (i_m_ready || w_timeout) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Registered outputs and datapath; strobes are decoded from the next state
    // so they line up with the state they belong to.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_last1   <= 1'b1;
            r_cnt     <= '0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_err     <= 1'b0;
            r_result  <= '0;
            r_busy    <= 1'b0;
            r_m_reset <= 1'b0;
            r_m_run   <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
        end else begin
            r_m_reset <= (w_next == S_LOAD);
            r_m_run   <= (w_next == S_RUN);
            r_busy    <= (w_next != S_IDLE);
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_next == S_LOAD) begin
                        r_gnt0   <= ~w_pick1;
                        r_gnt1   <= w_pick1;
                        r_mcand  <= w_pick1 ? i_a1 : i_a0;
                        r_mplier <= w_pick1 ? i_b1 : i_b0;
                    end
                end
                S_LOAD: begin
                    r_cnt <= '0;
                end
                S_RUN: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_next == S_DONE) begin
                        r_done0  <= r_gnt0;
                        r_done1  <= r_gnt1;
                        // m_ready wins over a simultaneous timeout.
                        r_err    <= ~i_m_ready;
                        r_result <= i_m_ready ? i_m_product : '0;
                    end
                end
                S_DONE: begin
                    r_last1 <= r_gnt1;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                end
                default: begin
                    r_gnt0 <= 1'b0;
                    r_gnt1 <= 1'b0;
                end
            endcase
        end
    end

    assign o_gnt0           = r_gnt0;
    assign o_gnt1           = r_gnt1;
    assign o_done0          = r_done0;
    assign o_done1          = r_done1;
    assign o_err            = r_err;
    assign o_result         = r_result;
    assign o_busy           = r_busy;
    assign o_m_reset        = r_m_reset;
    assign o_m_run          = r_m_run;
    assign o_m_multiplicand = r_mcand;
    assign o_m_multiplier   = r_mplier;

endmodule
